calc1_port_driver: RTL and testbench

- Per-port request sequencer that sits directly upstream of one calc1 request port.
- Accepts single-cycle transactions (cmd, op1, op2, tag) on a valid/ready interface and buffers them in a small FIFO.
- Serialises each transaction onto calc1's two-cycle cmd/data protocol, waits for the response and returns it with its tag.
- Exactly one transaction is outstanding at calc1 at any time; four instances drive the four calc1 ports.

---
 rtl/calc1_port_driver.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_calc1_port_driver.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_driver.sv
// ============================================================================
// calc1_port_driver
//
// Per-port request sequencer sitting directly upstream of one calc1 request
// port. Requests (cmd, op1, op2, tag) are accepted on a valid/ready interface
// and buffered in a small FIFO. Each request is serialised onto calc1's
// two-cycle cmd/data protocol. The driver waits for a non-zero response and
// hands it back with the caller's tag. Only one request is outstanding at
// calc1 at a time.
//
// Parameters
//   DEPTH    FIFO entries, power of two, 2..16
//   TIMEOUT  WAIT cycles allowed before a timeout response (resp=3) is made
//
// Ports
//   c_clk, reset_n             clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake
//   req_cmd/op1/op2/tag        request payload; cmd==0 is accepted, dropped
//   calc_cmd_out/data_out      registered drive to calc1 reqN_cmd/data_in
//   calc_resp_in/data_in       calc1 out_respN / out_dataN
//   rsp_valid/rsp_ready        response handshake
//   rsp_resp/data/tag          completed response (resp=3, data=0 on timeout)
//   busy                       FSM not idle or FIFO not empty
//   timeout_err                one-cycle pulse when a timeout response is made
//
// Optional build macro CALC1_DRV_STATS_EN adds saturating 16-bit counters:
//   stat_issued    requests launched (entries into SEND1)
//   stat_timeouts  timeout responses generated
//   stat_stray     non-zero calc_resp_in cycles seen outside WAIT
// ============================================================================
module calc1_port_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic [1:0]  req_tag,
    output logic [3:0]  calc_cmd_out,
    output logic [31:0] calc_data_out,
    input  logic [1:0]  calc_resp_in,
    input  logic [31:0] calc_data_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_tag,
    output logic        busy,
    output logic        timeout_err
`ifdef CALC1_DRV_STATS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_timeouts,
    output logic [15:0] stat_stray
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND1 = 3'd1,
        ST_SEND2 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [3:0]       r_fifo_cmd [DEPTH];
    logic [31:0]      r_fifo_op1 [DEPTH];
    logic [31:0]      r_fifo_op2 [DEPTH];
    logic [1:0]       r_fifo_tag [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_head_cmd;
    logic [31:0]      w_head_op1;
    logic [31:0]      w_head_op2;
    logic [1:0]       w_head_tag;

    // ------------------------------------------------------------------
    // FSM and working state
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [31:0]      r_wk_op2;
    logic [1:0]       r_wk_tag;
    logic             w_rsp_cap;
    logic             w_to_fire;
    logic [3:0]       w_cmd_nxt;
    logic [31:0]      w_data_nxt;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends only on occupancy, so a same-cycle pop never opens a slot.
    assign req_ready = !w_full;

    // Zero commands complete the handshake but never take a FIFO slot.
    assign w_push = req_valid && !w_full && (req_cmd != 4'd0);

    assign w_head_cmd = r_fifo_cmd[r_rd_ptr];
    assign w_head_op1 = r_fifo_op1[r_rd_ptr];
    assign w_head_op2 = r_fifo_op2[r_rd_ptr];
    assign w_head_tag = r_fifo_tag[r_rd_ptr];

    always_ff @(posedge c_clk) begin
        if (w_push) begin
            r_fifo_cmd[r_wr_ptr] <= req_cmd;
            r_fifo_op1[r_wr_ptr] <= req_op1;
            r_fifo_op2[r_wr_ptr] <= req_op2;
            r_fifo_tag[r_wr_ptr] <= req_tag;
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_rsp_cap   = 1'b0;
        w_to_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SEND1;
                end
            end
            ST_SEND1: w_state_nxt = ST_SEND2;
            ST_SEND2: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A real response on the final cycle wins over the timeout.
                if (calc_resp_in != 2'd0) begin
                    w_rsp_cap   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                    w_to_fire   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_SEND1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. The calc drive is computed from the next state so
    // that the registered outputs line up with the state they belong to.
    // SEND1 is only ever entered together with a pop, so the FIFO head is
    // the request being launched.
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_nxt  = 4'd0;
        w_data_nxt = 32'd0;
        case (w_state_nxt)
            ST_SEND1: begin
                w_cmd_nxt  = w_head_cmd;
                w_data_nxt = w_head_op1;
            end
            ST_SEND2: begin
                w_data_nxt = r_wk_op2;
            end
            default: begin
                w_cmd_nxt  = 4'd0;
                w_data_nxt = 32'd0;
            end
        endcase
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            calc_cmd_out  <= 4'd0;
            calc_data_out <= 32'd0;
        end else begin
            calc_cmd_out  <= w_cmd_nxt;
            calc_data_out <= w_data_nxt;
        end
    end

    // Working copy of the launched request; only op2 and tag outlive SEND1.
    always_ff @(posedge c_clk) begin
        if (w_pop) begin
            r_wk_op2 <= w_head_op2;
            r_wk_tag <= w_head_tag;
        end
    end

    // Cleared in SEND2 so the first WAIT cycle sees zero.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_SEND2) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Response registers hold steady through HOLD; only WAIT can load them.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_resp    <= 2'd0;
            rsp_data    <= 32'd0;
            rsp_tag     <= 2'd0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= w_to_fire;
            if (w_rsp_cap) begin
                rsp_resp <= calc_resp_in;
                rsp_data <= calc_data_in;
                rsp_tag  <= r_wk_tag;
            end else if (w_to_fire) begin
                rsp_resp <= 2'd3;
                rsp_data <= 32'd0;
                rsp_tag  <= r_wk_tag;
            end
        end
    end

    assign rsp_valid = (r_state == ST_HOLD);
    assign busy      = (r_state != ST_IDLE) || !w_empty;

`ifdef CALC1_DRV_STATS_EN
    logic w_stray;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Any response outside WAIT is dropped, e.g. a late reply after a timeout.
    assign w_stray = (calc_resp_in != 2'd0) && (r_state != ST_WAIT);

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued   <= 16'd0;
            stat_timeouts <= 16'd0;
            stat_stray    <= 16'd0;
        end else begin
            if (w_pop) begin
                stat_issued <= sat_inc16(stat_issued);
            end
            if (w_to_fire) begin
                stat_timeouts <= sat_inc16(stat_timeouts);
            end
            if (w_stray) begin
                stat_stray <= sat_inc16(stat_stray);
            end
        end
    end
`endif

endmodule

// File: tb/tb_calc1_port_driver.sv
// ============================================================================
// tb_calc1_port_driver
//
// Directed bench for calc1_port_driver with a small calc1 model that replies
// three cycles after the SEND2 beat. The model mode selects the reply:
//   0: resp=1, data=op1+op2    1: resp=2, data=0    2: never replies
// ============================================================================
module tb_calc1_port_driver;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        c_clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [1:0]  req_tag;
    logic [3:0]  calc_cmd_out;
    logic [31:0] calc_data_out;
    logic [1:0]  calc_resp_in;
    logic [31:0] calc_data_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_tag;
    logic        busy;
    logic        timeout_err;
`ifdef CALC1_DRV_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_timeouts;
    logic [15:0] stat_stray;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int          m_mode  = 0;
    bit          m_stray = 1'b0;
    bit          m_phase;
    int          m_dly;
    logic [31:0] m_op1;
    logic [31:0] m_op2;

    always #5 c_clk = ~c_clk;

    calc1_port_driver #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .c_clk         (c_clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .req_tag       (req_tag),
        .calc_cmd_out  (calc_cmd_out),
        .calc_data_out (calc_data_out),
        .calc_resp_in  (calc_resp_in),
        .calc_data_in  (calc_data_in),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_resp      (rsp_resp),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .busy          (busy),
        .timeout_err   (timeout_err)
`ifdef CALC1_DRV_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_timeouts (stat_timeouts),
        .stat_stray    (stat_stray)
`endif
    );

    // calc1 model, evaluated on the falling edge
    initial begin
        m_phase = 1'b0;
        m_dly   = 0;
        m_op1   = 32'd0;
        m_op2   = 32'd0;
        forever begin
            @(negedge c_clk);
            calc_resp_in = 2'd0;
            calc_data_in = 32'd0;
            if (m_stray) begin
                calc_resp_in = 2'd1;
                calc_data_in = 32'h0BAD_0BAD;
            end
            if (!reset_n) begin
                m_phase = 1'b0;
                m_dly   = 0;
            end else begin
                if (m_dly > 0) begin
                    m_dly = m_dly - 1;
                    if (m_dly == 0) begin
                        if (m_mode == 0) begin
                            calc_resp_in = 2'd1;
                            calc_data_in = m_op1 + m_op2;
                        end else if (m_mode == 1) begin
                            calc_resp_in = 2'd2;
                            calc_data_in = 32'd0;
                        end
                    end
                end
                if (m_phase) begin
                    m_op2   = calc_data_out;
                    m_phase = 1'b0;
                    m_dly   = 3;
                end else if (calc_cmd_out != 4'd0) begin
                    m_op1   = calc_data_out;
                    m_phase = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic push(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] t);
        bit acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_cmd   = c;
        req_op1   = a;
        req_op2   = b;
        req_tag   = t;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = req_ready;
            @(negedge c_clk);
        end
        req_valid = 1'b0;
        req_cmd   = 4'd0;
        check("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_rsp();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1;
            else @(negedge c_clk);
        end
        check("rsp_seen", 32'(seen), 32'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge c_clk);
        rsp_ready = 1'b0;
    endtask

    logic [3:0]  t3_cmd [5] = '{4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
    logic [31:0] t3_op1 [5] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500};
    logic [31:0] t3_op2 [5] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    logic [1:0]  t3_tag [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] t3_exp [5] = '{32'h101, 32'h202, 32'h303, 32'h404, 32'h505};

    initial begin
        bit flag;
        int cnt;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 4'd0;
        req_op1   = 32'd0;
        req_op2   = 32'd0;
        req_tag   = 2'd0;
        rsp_ready = 1'b0;

        // ---- reset state ----
        @(negedge c_clk);
        @(negedge c_clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_out", 32'(calc_cmd_out), 32'd0);
        check("rst_data_out", calc_data_out, 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        @(negedge c_clk);

        // ---- test 1: basic add, two-beat serialisation ----
        m_mode = 0;
        push(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd2);
        check("t1_idle_cmd", 32'(calc_cmd_out), 32'd0);
        @(negedge c_clk);
        check("t1_send1_cmd", 32'(calc_cmd_out), 32'd1);
        check("t1_send1_data", calc_data_out, 32'h0000_0001);
        @(negedge c_clk);
        check("t1_send2_cmd", 32'(calc_cmd_out), 32'd0);
        check("t1_send2_data", calc_data_out, 32'h01FF_FFFF);
        wait_rsp();
        check("t1_resp", 32'(rsp_resp), 32'd1);
        check("t1_data", rsp_data, 32'h0200_0000);
        check("t1_tag", 32'(rsp_tag), 32'd2);
        ack();
        check("t1_valid_drop", 32'(rsp_valid), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);

        // ---- test 2: error response, next issue waits for handshake ----
        m_mode = 1;
        push(4'd1, 32'hFFFF_FFFF, 32'h1, 2'd1);
        push(4'd5, 32'd10, 32'd20, 2'd3);
        wait_rsp();
        check("t2_resp", 32'(rsp_resp), 32'd2);
        check("t2_data", rsp_data, 32'd0);
        check("t2_tag", 32'(rsp_tag), 32'd1);
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge c_clk);
            if (calc_cmd_out != 4'd0 || !rsp_valid) flag = 1'b1;
        end
        check("t2_no_early_issue", 32'(flag), 32'd0);
        check("t2_busy_hold", 32'(busy), 32'd1);
        m_mode = 0;
        ack();
        check("t2_next_cmd", 32'(calc_cmd_out), 32'd5);
        check("t2_next_op1", calc_data_out, 32'd10);
        check("t2_valid_drop", 32'(rsp_valid), 32'd0);
        wait_rsp();
        check("t2b_resp", 32'(rsp_resp), 32'd1);
        check("t2b_data", rsp_data, 32'h1E);
        check("t2b_tag", 32'(rsp_tag), 32'd3);
        ack();

        // ---- test 3: back-pressure, FIFO full, ordered drain ----
        for (int i = 0; i < 5; i++) begin
            push(t3_cmd[i], t3_op1[i], t3_op2[i], t3_tag[i]);
        end
        check("t3_full_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_cmd   = 4'd9;
        req_tag   = 2'd1;
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge c_clk);
            if (req_ready) flag = 1'b1;
        end
        req_valid = 1'b0;
        req_cmd   = 4'd0;
        check("t3_ready_stays_low", 32'(flag), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp();
            check($sformatf("t3_tag%0d", i), 32'(rsp_tag), 32'(t3_tag[i]));
            check($sformatf("t3_data%0d", i), rsp_data, t3_exp[i]);
            check($sformatf("t3_resp%0d", i), 32'(rsp_resp), 32'd1);
            @(negedge c_clk);
        end
        rsp_ready = 1'b0;
        @(negedge c_clk);
        check("t3_drained_busy", 32'(busy), 32'd0);
        check("t3_drained_ready", 32'(req_ready), 32'd1);

        // ---- cmd=0 is accepted but produces nothing ----
        push(4'd0, 32'hDEAD, 32'hBEEF, 2'd1);
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (calc_cmd_out != 4'd0 || calc_data_out != 32'd0 || busy || rsp_valid) flag = 1'b1;
            @(negedge c_clk);
        end
        check("t3_cmd0_silent", 32'(flag), 32'd0);

        // ---- test 4: timeout, then a stray late response ----
        m_mode = 2;
        push(4'd3, 32'd7, 32'd9, 2'd1);
        for (int k = 0; k < 20 && calc_cmd_out != 4'd3; k++) @(negedge c_clk);
        check("t4_send1_seen", 32'(calc_cmd_out), 32'd3);
        cnt = 0;
        while (!rsp_valid && cnt < 200) begin
            @(negedge c_clk);
            cnt++;
        end
        // SEND1 -> SEND2 -> 64 WAIT cycles -> HOLD
        check("t4_latency", 32'(cnt), 32'(TIMEOUT + 2));
        check("t4_timeout_err", 32'(timeout_err), 32'd1);
        check("t4_resp", 32'(rsp_resp), 32'd3);
        check("t4_data", rsp_data, 32'd0);
        check("t4_tag", 32'(rsp_tag), 32'd1);
        @(negedge c_clk);
        check("t4_err_one_pulse", 32'(timeout_err), 32'd0);
        check("t4_still_valid", 32'(rsp_valid), 32'd1);
        ack();
        @(negedge c_clk);
        @(posedge c_clk);
        m_stray = 1'b1;
        @(posedge c_clk);
        m_stray = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge c_clk);
            if (rsp_valid || busy || timeout_err) flag = 1'b1;
        end
        check("t4_stray_ignored", 32'(flag), 32'd0);
`ifdef CALC1_DRV_STATS_EN
        check("t4_stat_stray", 32'(stat_stray), 32'd1);
        check("t4_stat_timeouts", 32'(stat_timeouts), 32'd1);
        check("t4_stat_issued", 32'(stat_issued), 32'd9);
`endif

        // ---- test 5: reset during WAIT with two queued ----
        m_mode = 2;
        push(4'd1, 32'd1, 32'd2, 2'd0);
        push(4'd1, 32'd3, 32'd4, 2'd1);
        push(4'd1, 32'd5, 32'd6, 2'd2);
        for (int i = 0; i < 4; i++) @(negedge c_clk);
        check("t5_busy_before", 32'(busy), 32'd1);
        check("t5_ready_before", 32'(req_ready), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_ready", 32'(req_ready), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_tag", 32'(rsp_tag), 32'd0);
        check("t5_rst_resp", 32'(rsp_resp), 32'd0);
        check("t5_rst_cmd", 32'(calc_cmd_out), 32'd0);
`ifdef CALC1_DRV_STATS_EN
        check("t5_rst_stat_issued", 32'(stat_issued), 32'd0);
`endif
        @(negedge c_clk);
        @(negedge c_clk);
        m_mode  = 0;
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge c_clk);
            if (rsp_valid || calc_cmd_out != 4'd0 || busy) flag = 1'b1;
        end
        rsp_ready = 1'b0;
        check("t5_no_activity", 32'(flag), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
